// File: rtl/hamming_pkg.sv
// hamming_pkg: shared constants and index mapping for the 26-bit Hamming SECDED encoder/decoder.
package hamming_pkg;
    localparam int DATA_W = 26;
    localparam int CODE_W = 32;
    localparam int PAR_IDX [6] = '{0, 1, 3, 7, 15, 31};
    // Bit k selects codeword indices i in 0..30 whose Hamming position i+1 has bit k set.
    localparam logic [CODE_W-1:0] SYN_MASK [5] = '{
        32'h5555_5555, 32'h6666_6666, 32'h7878_7878, 32'h7F80_7F80, 32'h7FFF_8000
    };

    function automatic logic [4:0] data_idx(input int j);
        return 5'(j == 0 ? 2 : j < 4 ? j + 3 : j < 11 ? j + 4 : j + 5);
    endfunction
endpackage

// File: rtl/hamming_syndrome.sv
// hamming_syndrome: combinational syndrome S[4:0] and overall parity P of a 32-bit codeword.
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CODE_W-1:0] in_code,
    output logic [4:0]        syn,
    output logic              par
);
    for (genvar k = 0; k < 5; k++) begin : g_syn
        assign syn[k] = ^(in_code & SYN_MASK[k]);
    end
    assign par = ^in_code;
endmodule

// File: rtl/hamming_decoder.sv
// hamming_decoder: two-stage SECDED decoder with valid/ready on both sides.
// Optional saturating error counters under HAMMING_DEC_STATS_EN.
module hamming_decoder
    import hamming_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
`ifdef HAMMING_DEC_STATS_EN
    input  logic              stats_clear,
    output logic [15:0]       sec_count,
    output logic [15:0]       ded_count,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sec,
    output logic              out_ded,
    output logic [4:0]        out_err_idx
);
    logic [4:0]        syn, s1_syn, err_idx;
    logic              par, s1_par, s1_valid, s2_valid, s2_ready, hit, ded;
    logic [CODE_W-1:0] s1_code, fixed;
    logic [DATA_W-1:0] cor_data;

    hamming_syndrome u_syn (.in_code(in_code), .syn(syn), .par(par));

    assign s2_ready  = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_ready;
    assign out_valid = s2_valid;

    assign hit     = s1_syn != 5'd0;
    assign ded     = hit && !s1_par;
    assign err_idx = !s1_par ? 5'd0 : hit ? s1_syn - 5'd1 : 5'd31;
    // A parity-only error flips index 31, which no data bit maps to.
    assign fixed   = s1_code ^ (s1_par ? 32'd1 << err_idx : 32'd0);

    for (genvar j = 0; j < DATA_W; j++) begin : g_ext
        assign cor_data[j] = fixed[data_idx(j)];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= in_code;
                s1_syn  <= syn;
                s1_par  <= par;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid    <= 1'b0;
            out_data    <= '0;
            out_sec     <= 1'b0;
            out_ded     <= 1'b0;
            out_err_idx <= '0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data    <= cor_data;
                out_sec     <= s1_par;
                out_ded     <= ded;
                out_err_idx <= err_idx;
            end
        end
    end

`ifdef HAMMING_DEC_STATS_EN
    logic pop;
    assign pop = out_valid && out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sec_count <= '0;
            ded_count <= '0;
        end else if (stats_clear) begin
            sec_count <= '0;
            ded_count <= '0;
        end else begin
            sec_count <= sec_count + 16'((pop && out_sec && sec_count != 16'hFFFF) ? 1 : 0);
            ded_count <= ded_count + 16'((pop && out_ded && ded_count != 16'hFFFF) ? 1 : 0);
        end
    end
`endif
endmodule

// File: tb/tb_hamming_decoder.sv
// tb_hamming_decoder: directed self-checking bench for hamming_decoder.
module tb_hamming_decoder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_code = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [25:0] out_data;
    logic        out_sec;
    logic        out_ded;
    logic [4:0]  out_err_idx;
    int          errors = 0;
    int          checks = 0;
`ifdef HAMMING_DEC_STATS_EN
    logic        stats_clear = 1'b0;
    logic [15:0] sec_count, ded_count;
    logic [15:0] ded_before;
`endif

    hamming_decoder dut (
        .clock(clock),
        .reset(reset),
`ifdef HAMMING_DEC_STATS_EN
        .stats_clear(stats_clear),
        .sec_count(sec_count),
        .ded_count(ded_count),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_code(in_code),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_sec(out_sec),
        .out_ded(out_ded),
        .out_err_idx(out_err_idx)
    );

    always #5 clock = !clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {err_idx, sec, ded, data}
    function automatic logic [63:0] sig(input logic [4:0] i, input logic s, input logic d,
                                        input logic [25:0] dat);
        return {31'd0, i, s, d, dat};
    endfunction

    function automatic logic [63:0] cur();
        return sig(out_err_idx, out_sec, out_ded, out_data);
    endfunction

    task automatic send_one(input string tag, input logic [31:0] code, input logic [63:0] exp);
        @(negedge clock);
        in_valid  = 1'b1;
        in_code   = code;
        out_ready = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
        @(negedge clock);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_fields"}, cur(), exp);
    endtask

    logic [31:0] words [4] = '{32'h8000_0007, 32'h8000_0027, 32'h0000_0007, 32'h8000_0037};
    logic [63:0] exps  [4];
    int sent, rcv;

    initial begin
        exps[0] = sig(5'd0, 1'b0, 1'b0, 26'h1);
        exps[1] = sig(5'd5, 1'b1, 1'b0, 26'h1);
        exps[2] = sig(5'd31, 1'b1, 1'b0, 26'h1);
        exps[3] = sig(5'd0, 1'b0, 1'b1, 26'h7);

        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_fields", cur(), 64'd0);
`ifdef HAMMING_DEC_STATS_EN
        chk("rst_counts", {32'd0, sec_count, ded_count}, 64'd0);
`endif
        repeat (2) @(negedge clock);
        reset = 1'b0;

        send_one("clean", 32'h8000_0007, exps[0]);
        send_one("sec_idx5", 32'h8000_0027, exps[1]);
        send_one("sec_par", 32'h0000_0007, exps[2]);
        send_one("sec_data0", 32'h8000_0003, sig(5'd2, 1'b1, 1'b0, 26'h1));
`ifdef HAMMING_DEC_STATS_EN
        @(negedge clock);
        ded_before = ded_count;
`endif
        send_one("ded", 32'h8000_0037, exps[3]);
`ifdef HAMMING_DEC_STATS_EN
        @(negedge clock);
        chk("ded_count_inc", {48'd0, ded_count}, {48'd0, ded_before + 16'd1});
        stats_clear = 1'b1;
        @(negedge clock);
        stats_clear = 1'b0;
        chk("stats_clear", {32'd0, sec_count, ded_count}, 64'd0);
`endif

        // Back-pressure: out_ready low on loop cycles 2..5.
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
            @(negedge clock);
            out_ready = !(cyc >= 2 && cyc <= 5);
            in_valid  = sent < 4;
            in_code   = words[sent < 4 ? sent : 0];
            #1;
            if (cyc >= 2 && cyc <= 5) begin
                chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
                chk("bp_sent_two", 64'(sent), 64'd2);
                chk("bp_stable", {out_valid, cur()[62:0]}, {1'b1, exps[0][62:0]});
            end
            if (out_valid && out_ready) begin
                chk("bp_order", cur(), exps[rcv]);
                rcv++;
            end
            if (in_valid && in_ready) sent++;
        end
        chk("bp_received", 64'(rcv), 64'd4);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("bp_no_dup", {63'd0, out_valid}, 64'd0);
        end

        // Reset with two words in flight.
        @(negedge clock);
        in_valid = 1'b1;
        in_code  = 32'h8000_0027;
        @(negedge clock);
        in_code = 32'h0000_0007;
        @(negedge clock);
        in_valid = 1'b0;
        chk("inflight_valid", {63'd0, out_valid}, 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("post_rst_no_stale", {63'd0, out_valid}, 64'd0);
        end
        send_one("post_rst", 32'h8000_0007, exps[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
